// File: rtl/axi_sram_slave.sv
// AXI4 slave in front of a single-ported-per-direction 32-bit word SRAM.
// The read and write channels run independent FSMs that share the word array.
package axi_sram_pkg;
    typedef struct packed {
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arlock;
        logic [3:0]  arcache;
        logic [2:0]  arprot;
        logic        arvalid;
        logic        rready;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awlock;
        logic [3:0]  awcache;
        logic [2:0]  awprot;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
    } axi_req_t;

    typedef struct packed {
        logic        arready;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        rvalid;
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
    } axi_resp_t;
endpackage

module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  axi_req_t   axi_req,
    output axi_resp_t  axi_resp,
    output logic       o_dbg_r_state,
    output logic [1:0] o_dbg_w_state
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Every channel moves a beat only on the cycle where its valid and ready are both high;
    // a source holds its payload stable from valid until that cycle.
    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    function automatic logic [ADDR_WIDTH-1:0] next_index(
        input logic [ADDR_WIDTH-1:0] idx,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] inc;
        mask = ADDR_WIDTH'(len[3:0]);
        inc  = idx + ADDR_WIDTH'(1);
        case (burst)
            2'b01:   next_index = inc;
            2'b10:   next_index = (idx & ~mask) | (inc & mask);
            default: next_index = idx;
        endcase
    endfunction

    function automatic logic bad_burst(input logic [7:0] len, input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        bad_burst   = (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    logic [31:0] r_mem [0:DEPTH-1];
    logic [31:0] r_rdata;

    // Read channel state
    r_state_t              r_rstate;
    r_state_t              w_rstate_nxt;
    logic [ADDR_WIDTH-1:0] r_ridx;
    logic [7:0]            r_rlen;
    logic [1:0]            r_rburst;
    logic [7:0]            r_rcnt;
    logic                  r_roor;
    logic                  r_rbad;
    logic                  w_arready;
    logic                  w_rvalid;
    logic                  w_rlast;
    logic                  w_rerr;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic [ADDR_WIDTH-1:0] w_ridx_nxt;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_rd_idx;

    // Write channel state
    w_state_t              r_wstate;
    w_state_t              w_wstate_nxt;
    logic [ADDR_WIDTH-1:0] r_widx;
    logic [7:0]            r_wlen;
    logic [1:0]            r_wburst;
    logic [8:0]            r_wcnt;
    logic                  r_woor;
    logic                  r_wbad;
    logic                  r_werr;
    logic                  w_awready;
    logic                  w_wready;
    logic                  w_bvalid;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_cnt_ok;
    logic                  w_at_len;
    logic                  w_beat_err;
    logic                  w_wr_en;

    logic                  w_unused_fields;
    assign w_unused_fields = ^{axi_req.arsize, axi_req.arlock, axi_req.arcache, axi_req.arprot,
                               axi_req.awsize, axi_req.awlock, axi_req.awcache, axi_req.awprot,
                               axi_req.araddr[1:0], axi_req.awaddr[1:0]};

    // ---------------- read FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_BURST;
            R_BURST: if (w_r_hs && w_rlast) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        if (!rst) begin
            w_arready = (r_rstate == R_IDLE);
            w_rvalid  = (r_rstate == R_BURST);
        end
    end

    assign w_ar_hs    = w_arready & axi_req.arvalid;
    assign w_r_hs     = w_rvalid & axi_req.rready;
    assign w_rlast    = (r_rcnt == r_rlen);
    assign w_rerr     = r_roor | r_rbad;
    assign w_ridx_nxt = next_index(r_ridx, r_rlen, r_rburst);

    // The array is read on the edge that opens a beat, so rdata stays put through stalls.
    always_comb begin
        w_rd_en  = 1'b0;
        w_rd_idx = r_ridx;
        if (w_ar_hs) begin
            w_rd_en  = 1'b1;
            w_rd_idx = axi_req.araddr[ADDR_WIDTH+1:2];
        end else if (w_r_hs && !w_rlast) begin
            w_rd_en  = 1'b1;
            w_rd_idx = w_ridx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ridx   <= '0;
            r_rlen   <= '0;
            r_rburst <= '0;
            r_rcnt   <= '0;
            r_roor   <= 1'b0;
            r_rbad   <= 1'b0;
        end else if (w_ar_hs) begin
            r_ridx   <= axi_req.araddr[ADDR_WIDTH+1:2];
            r_rlen   <= axi_req.arlen;
            r_rburst <= axi_req.arburst;
            r_rcnt   <= '0;
            r_roor   <= |axi_req.araddr[31:ADDR_WIDTH+2];
            r_rbad   <= bad_burst(axi_req.arlen, axi_req.arburst);
        end else if (w_r_hs && !w_rlast) begin
            r_ridx   <= w_ridx_nxt;
            r_rcnt   <= r_rcnt + 8'd1;
        end
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_wstate <= W_IDLE;
        else     r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && axi_req.wlast) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        if (!rst) begin
            w_awready = (r_wstate == W_IDLE);
            w_wready  = (r_wstate == W_DATA);
            w_bvalid  = (r_wstate == W_RESP);
        end
    end

    assign w_aw_hs  = w_awready & axi_req.awvalid;
    assign w_w_hs   = w_wready & axi_req.wvalid;
    assign w_b_hs   = w_bvalid & axi_req.bready;
    assign w_cnt_ok = (r_wcnt <= {1'b0, r_wlen});
    assign w_at_len = (r_wcnt == {1'b0, r_wlen});
    // wlast must coincide exactly with beat awlen; either side of it is a protocol error.
    assign w_beat_err = (axi_req.wlast != w_at_len);
    assign w_wr_en    = w_w_hs & w_cnt_ok & ~r_woor & ~r_wbad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_widx   <= '0;
            r_wlen   <= '0;
            r_wburst <= '0;
            r_wcnt   <= '0;
            r_woor   <= 1'b0;
            r_wbad   <= 1'b0;
            r_werr   <= 1'b0;
        end else if (w_aw_hs) begin
            r_widx   <= axi_req.awaddr[ADDR_WIDTH+1:2];
            r_wlen   <= axi_req.awlen;
            r_wburst <= axi_req.awburst;
            r_wcnt   <= '0;
            r_woor   <= |axi_req.awaddr[31:ADDR_WIDTH+2];
            r_wbad   <= bad_burst(axi_req.awlen, axi_req.awburst);
            r_werr   <= (|axi_req.awaddr[31:ADDR_WIDTH+2]) | bad_burst(axi_req.awlen, axi_req.awburst);
        end else if (w_w_hs) begin
            r_widx   <= next_index(r_widx, r_wlen, r_wburst);
            r_wcnt   <= (r_wcnt == 9'h1FF) ? r_wcnt : r_wcnt + 9'd1;
            r_werr   <= r_werr | w_beat_err;
        end
    end

    // ---------------- shared array (not reset) ----------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (axi_req.wstrb[i]) r_mem[r_widx][8*i +: 8] <= axi_req.wdata[8*i +: 8];
            end
        end
        if (w_rd_en) r_rdata <= r_mem[w_rd_idx];
    end

    // ---------------- response assembly ----------------
    always_comb begin
        axi_resp         = '0;
        axi_resp.arready = w_arready;
        axi_resp.rvalid  = w_rvalid;
        axi_resp.rdata   = (w_rvalid && !w_rerr) ? r_rdata : 32'h0;
        axi_resp.rresp   = (w_rvalid && w_rerr) ? 2'b10 : 2'b00;
        axi_resp.rlast   = w_rvalid & w_rlast;
        axi_resp.awready = w_awready;
        axi_resp.wready  = w_wready;
        axi_resp.bvalid  = w_bvalid;
        axi_resp.bresp   = (w_bvalid && r_werr) ? 2'b10 : 2'b00;
    end

    assign o_dbg_r_state = r_rstate;
    assign o_dbg_w_state = r_wstate;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: hand-computed read data, responses and handshake timing.
module tb_axi_sram_slave;
    import axi_sram_pkg::*;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    axi_req_t   req;
    axi_resp_t  resp;
    logic       dbg_r;
    logic [1:0] dbg_w;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wd_q[$];

    always #5 clk = ~clk;

    axi_sram_slave #(.ADDR_WIDTH(12)) dut (
        .clk           (clk),
        .rst           (rst),
        .axi_req       (req),
        .axi_resp      (resp),
        .o_dbg_r_state (dbg_r),
        .o_dbg_w_state (dbg_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b);
        int t = 0;
        req.araddr = a; req.arlen = len; req.arburst = b; req.arvalid = 1'b1;
        #1;
        while (!resp.arready && t < 50) begin @(posedge clk); #2; t++; end
        check("arready", resp.arready, 1);
        step();
        req.arvalid = 1'b0;
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b);
        int t = 0;
        req.awaddr = a; req.awlen = len; req.awburst = b; req.awvalid = 1'b1;
        #1;
        while (!resp.awready && t < 50) begin @(posedge clk); #2; t++; end
        check("awready", resp.awready, 1);
        step();
        req.awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic last);
        int t = 0;
        req.wdata = d; req.wstrb = s; req.wlast = last; req.wvalid = 1'b1;
        #1;
        while (!resp.wready && t < 50) begin @(posedge clk); #2; t++; end
        check("wready", resp.wready, 1);
        step();
        req.wvalid = 1'b0; req.wlast = 1'b0;
    endtask

    task automatic do_b(input logic [1:0] exp_bresp);
        int t = 0;
        req.bready = 1'b1;
        #1;
        while (!resp.bvalid && t < 50) begin @(posedge clk); #2; t++; end
        check("bvalid", resp.bvalid, 1);
        check("bresp", resp.bresp, exp_bresp);
        step();
        req.bready = 1'b0;
    endtask

    // Beats take data from wd_q; wlast is raised on beat index last_at.
    task automatic write_burst(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b,
                               input int nbeats, input int last_at, input logic [3:0] s,
                               input logic [1:0] exp_bresp);
        do_aw(a, len, b);
        for (int i = 0; i < nbeats; i++) do_w(wd_q.pop_front(), s, i == last_at);
        do_b(exp_bresp);
    endtask

    // Pops len+1 expected words from exp_q; with stall, every beat after the first sits one cycle with rready=0.
    task automatic read_burst(input logic [7:0] len, input logic [1:0] exp_rresp, input bit stall);
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] e;
            int t;
            e = exp_q.pop_front();
            t = 0;
            if (stall && i > 0) begin
                req.rready = 1'b0;
                #1;
                check("r_stall_valid", resp.rvalid, 1);
                check("r_stall_data", resp.rdata, e);
                check("r_stall_last", resp.rlast, i == int'(len));
                step();
            end
            req.rready = 1'b1;
            #1;
            while (!resp.rvalid && t < 50) begin @(posedge clk); #2; t++; end
            check("rvalid", resp.rvalid, 1);
            check("rdata", resp.rdata, e);
            check("rresp", resp.rresp, exp_rresp);
            check("rlast", resp.rlast, i == int'(len));
            step();
            req.rready = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0;
        rst = 1'b1;
        repeat (3) step();
        check("rst_arready", resp.arready, 0);
        check("rst_awready", resp.awready, 0);
        check("rst_rvalid", resp.rvalid, 0);
        check("rst_bvalid", resp.bvalid, 0);
        check("rst_wready", resp.wready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_arready", resp.arready, 1);
        check("post_rst_awready", resp.awready, 1);
        step();

        // W presented before any AW must not be taken
        req.wvalid = 1'b1; req.wdata = 32'h12345678; req.wstrb = 4'hF; req.wlast = 1'b1;
        #1;
        check("w_before_aw", resp.wready, 0);
        step();
        req.wvalid = 1'b0; req.wlast = 1'b0;

        // single write then read
        wd_q.push_back(32'hDEADBEEF);
        write_burst(32'h10, 8'd0, INCR, 1, 0, 4'hF, 2'b00);
        check("r_idle_no_valid", resp.rvalid, 0);
        do_ar(32'h10, 8'd0, INCR);
        check("r_latency", resp.rvalid, 1);
        exp_q.push_back(32'hDEADBEEF);
        read_burst(8'd0, 2'b00, 1'b0);

        // INCR burst, read back with rready toggling
        for (int i = 0; i < 4; i++) wd_q.push_back(32'h100 + i);
        write_burst(32'h0, 8'd3, INCR, 4, 3, 4'hF, 2'b00);
        do_ar(32'h0, 8'd3, INCR);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + i);
        read_burst(8'd3, 2'b00, 1'b1);

        // WRAP from word 2 of a 4-word window, then an illegal WRAP length
        do_ar(32'h8, 8'd3, WRAP);
        exp_q.push_back(32'h102); exp_q.push_back(32'h103);
        exp_q.push_back(32'h100); exp_q.push_back(32'h101);
        read_burst(8'd3, 2'b00, 1'b0);
        do_ar(32'h0, 8'd2, WRAP);
        repeat (3) exp_q.push_back(32'h0);
        read_burst(8'd2, 2'b10, 1'b0);

        // FIXED burst repeats the same word
        do_ar(32'h0, 8'd1, FIXED);
        exp_q.push_back(32'h100); exp_q.push_back(32'h100);
        read_burst(8'd1, 2'b00, 1'b0);

        // byte strobes
        wd_q.push_back(32'h11223344);
        write_burst(32'h40, 8'd0, INCR, 1, 0, 4'hF, 2'b00);
        wd_q.push_back(32'hAABBCCDD);
        write_burst(32'h40, 8'd0, INCR, 1, 0, 4'b0101, 2'b00);
        do_ar(32'h40, 8'd0, INCR);
        exp_q.push_back(32'h11BB33DD);
        read_burst(8'd0, 2'b00, 1'b0);

        // out-of-range write aliases word 0 in the low bits; word 0 must keep 0x100
        wd_q.push_back(32'hCAFEF00D);
        write_burst(32'h8000_0000, 8'd0, INCR, 1, 0, 4'hF, 2'b10);
        do_ar(32'h0, 8'd0, INCR);
        exp_q.push_back(32'h100);
        read_burst(8'd0, 2'b00, 1'b0);
        do_ar(32'h8000_0000, 8'd0, INCR);
        exp_q.push_back(32'h0);
        read_burst(8'd0, 2'b10, 1'b0);

        // reserved burst type: write suppressed, SLVERR
        wd_q.push_back(32'h55);
        write_burst(32'h4, 8'd0, 2'b11, 1, 0, 4'hF, 2'b10);
        do_ar(32'h4, 8'd0, INCR);
        exp_q.push_back(32'h101);
        read_burst(8'd0, 2'b00, 1'b0);

        // early wlast (beat 2 of 4): in-range beats land, bresp SLVERR
        wd_q.push_back(32'h200); wd_q.push_back(32'h201);
        write_burst(32'h20, 8'd3, INCR, 2, 1, 4'hF, 2'b10);
        do_ar(32'h20, 8'd1, INCR);
        exp_q.push_back(32'h200); exp_q.push_back(32'h201);
        read_burst(8'd1, 2'b00, 1'b0);

        // late wlast: the surplus beat is not written
        wd_q.push_back(32'hA0); wd_q.push_back(32'hA1);
        write_burst(32'h30, 8'd0, INCR, 2, 1, 4'hF, 2'b10);
        do_ar(32'h30, 8'd0, INCR);
        exp_q.push_back(32'hA0);
        read_burst(8'd0, 2'b00, 1'b0);

        // AR and W handshake on the same edge to word 0x40: read sees the old value
        do_aw(32'h40, 8'd0, INCR);
        req.araddr = 32'h40; req.arlen = 8'd0; req.arburst = INCR; req.arvalid = 1'b1;
        req.wdata = 32'h99999999; req.wstrb = 4'hF; req.wlast = 1'b1; req.wvalid = 1'b1;
        #1;
        check("same_cycle_arready", resp.arready, 1);
        check("same_cycle_wready", resp.wready, 1);
        step();
        req.arvalid = 1'b0; req.wvalid = 1'b0; req.wlast = 1'b0;
        exp_q.push_back(32'h11BB33DD);
        read_burst(8'd0, 2'b00, 1'b0);
        do_b(2'b00);
        do_ar(32'h40, 8'd0, INCR);
        exp_q.push_back(32'h99999999);
        read_burst(8'd0, 2'b00, 1'b0);

        // reset in the middle of a read burst
        do_ar(32'h0, 8'd3, INCR);
        req.rready = 1'b1;
        #1;
        check("pre_rst_rdata", resp.rdata, 32'h100);
        check("pre_rst_rlast", resp.rlast, 0);
        step();
        req.rready = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid", resp.rvalid, 0);
        check("mid_rst_arready", resp.arready, 0);
        check("mid_rst_rdata", resp.rdata, 0);
        step();
        rst = 1'b0;
        #1;
        check("after_rst_arready", resp.arready, 1);
        check("after_rst_rvalid", resp.rvalid, 0);
        step();
        do_ar(32'h8, 8'd0, INCR);
        exp_q.push_back(32'h102);
        read_burst(8'd0, 2'b00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, giving the word-index width; capacity is 2^ADDR_WIDTH 32-bit words.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port axi_req  input  axi_req_t  AXI master request (ar/r/aw/w/b fields).
REQ-005 SHALL have port axi_resp  output  axi_resp_t  AXI slave response.
REQ-006 SHALL ignore arlock/arcache/arprot/awlock/awcache/awprot and arsize/awsize; every beat is 32-bit, and wstrb carries narrow writes.

Function
REQ-007 SHALL implement independent read and write FSMs sharing one word array: one read port and one byte-enabled write port.
REQ-008 SHALL treat an address as in range iff addr[31:ADDR_WIDTH+2]==0; word index = addr[ADDR_WIDTH+1:2]; addr[1:0] ignored.
REQ-009 Read FSM SHALL have states R_IDLE and R_BURST.
- arready=1 only in R_IDLE and rst=0.
- On arvalid&arready: capture addr, arlen, arburst; beat counter=0; go to R_BURST.
REQ-010 In R_BURST the read FSM SHALL drive rvalid=1.
- Data: rdata=mem[current index]; rresp=2'b00; rlast=(counter==len).
- First rvalid is exactly 1 cycle after the AR handshake.
REQ-011 rdata/rresp/rlast SHALL be held stable while rvalid=1 and rready=0.
REQ-012 On rvalid&rready with rlast=0, the read FSM SHALL advance the address and counter; with rlast=1 it SHALL return to R_IDLE, so the next AR is accepted no earlier than the following cycle.
REQ-013 Address advance SHALL follow the burst type.
- FIXED (00): address unchanged.
- INCR (01): +4, wrapping modulo 2^ADDR_WIDTH words.
- WRAP (10): +4 within a (len+1)*4-byte aligned window; low log2(len+1) index bits wrap.
REQ-014 Burst type 2'b11, or WRAP with len not in {1,3,7,15}, SHALL give SLVERR (2'b10) on every beat.
- Full beat count len+1 still completes.
- rdata=0, and writes are suppressed.
REQ-015 Out-of-range read beats SHALL return rresp=2'b10 and rdata=0; out-of-range write beats SHALL be discarded and force bresp=2'b10.
REQ-016 Write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1) and W_RESP (bvalid=1).
- awready, wready and bvalid are 0 in all other states and while rst=1.
REQ-017 On awvalid&awready the write FSM SHALL capture awaddr, awlen and awburst, and go to W_DATA.
- W beats presented before the AW handshake are not accepted.
REQ-018 On wvalid&wready the write FSM SHALL write each byte i where wstrb[i]=1 to the current word.
- Bytes with wstrb[i]=0 are unchanged.
- Address and counter then advance per REQ-013.
REQ-019 The W burst SHALL end on the handshake with wlast=1, and the FSM then goes to W_RESP.
- Beats after counter exceeds awlen are accepted but not written.
- Any wlast/awlen mismatch, early or late, sets bresp=2'b10; otherwise bresp=2'b00.
REQ-020 In W_RESP the write FSM SHALL hold bvalid=1 and bresp stable until bready=1, then go to W_IDLE.
REQ-021 A same-cycle read and write to one word SHALL return the pre-write data (read-first).
REQ-022 Write data SHALL be visible to a read beat issued in any later cycle.
REQ-023 The read and write FSMs SHALL progress concurrently with no mutual blocking.

Reset
REQ-024 While rst=1, the block SHALL drive all axi_resp fields to 0 and force both FSMs to their IDLE states.
REQ-025 arready and awready SHALL be 1 in the first cycle after rst deasserts.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 Reset asserted mid-burst SHALL abort both FSMs; no further beat or B response is issued for that burst.

Verification
REQ-028 Single write then read:
- AW addr=0x10 len=0 INCR; W data=0xDEADBEEF strb=1111 wlast=1 -> bresp=00.
- Then AR 0x10 len=0 -> rdata=0xDEADBEEF, rlast=1, rvalid 1 cycle after AR handshake.
REQ-029 INCR burst with backpressure:
- Write words 0..3 (values 0x100+i) via len=3 at 0x0.
- Read back len=3 with rready toggling 1,0,1,0 -> four beats in order, stable during stalls, rlast on beat 4 only.
REQ-030 WRAP burst:
- AR addr=0x08 len=3 WRAP -> word indices 2,3,0,1.
- AR len=2 WRAP -> three beats with rresp=10.
REQ-031 Byte strobes and errors:
- Preload 0x11223344, write 0xAABBCCDD strb=0101 -> readback 0x11BB33DD.
- Write to 0x8000_0000 -> bresp=10, memory unchanged.
- wlast on beat 2 of len=3 -> bresp=10.
REQ-032 Concurrency and reset:
- Simultaneous read and write to the same word -> old data returned.
- rst pulsed during an R burst -> rvalid=0 during reset, arready=1 the cycle after, next AR serviced normally.
